// File: rtl/peak_detector_if.sv
// peak_detector_if
// Report channel from the peak detector to its consumer.
//
// Signals:
//   peak_valid  producer -> consumer  a report is being offered
//   peak_ready  consumer -> producer  consumer takes the report this cycle
//   peak_amp    producer -> consumer  maximum sample of the pulse
//   peak_ts     producer -> consumer  timestamp of the first maximal sample
//   peak_width  producer -> consumer  samples above threshold (saturating)
//
// Handshake: a report transfers on a rising clk edge where peak_valid and
// peak_ready are both high. Once peak_valid is raised, it and the payload
// hold stable until that transfer happens. peak_valid never depends
// combinationally on peak_ready.
interface peak_detector_if #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int SIZE_TS          = 32,
    parameter int SIZE_WIDTH       = 8
);
    logic                        peak_valid;
    logic                        peak_ready;
    logic [SIZE_FILTER_DATA-1:0] peak_amp;
    logic [SIZE_TS-1:0]          peak_ts;
    logic [SIZE_WIDTH-1:0]       peak_width;

    modport master (
        output peak_valid,
        output peak_amp,
        output peak_ts,
        output peak_width,
        input  peak_ready
    );

    modport slave (
        input  peak_valid,
        input  peak_amp,
        input  peak_ts,
        input  peak_width,
        output peak_ready
    );
endinterface

// File: rtl/peak_detector.sv
// peak_detector
// Watches one filtered sample stream for pulses that rise strictly above a
// programmable threshold. For every pulse it reports the peak amplitude, the
// timestamp of the first sample equal to that peak and the pulse width, then
// holds off for a programmable dead time. Reports that arrive while the
// single-entry output register is still waiting for the consumer are dropped
// and counted.
//
// Ports:
//   clk         system clock, one sample per cycle
//   reset       asynchronous, active-high reset
//   input_data  filter output sample (unsigned)
//   threshold   trigger level, sampled only while idle
//   dead_time   hold-off length, sampled when a pulse ends
//   rpt         report channel (master side of peak_detector_if)
//   lost_count  reports dropped because the output was full (saturating)
//   state_dbg   current FSM state: 0 idle, 1 pulse, 2 dead
module peak_detector #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int SIZE_TS          = 32,
    parameter int SIZE_WIDTH       = 8,
    parameter int SIZE_DEAD        = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SIZE_FILTER_DATA-1:0] input_data,
    input  logic [SIZE_FILTER_DATA-1:0] threshold,
    input  logic [SIZE_DEAD-1:0]        dead_time,
    peak_detector_if.master             rpt,
    output logic [15:0]                 lost_count,
    output logic [1:0]                  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Stage 1: sample and its timestamp, registered together.
    logic [SIZE_TS-1:0]          ts_cnt;
    logic [SIZE_TS-1:0]          ts_r;
    logic [SIZE_FILTER_DATA-1:0] x_r;

    // Pulse tracking state.
    logic [SIZE_FILTER_DATA-1:0] thr_l;
    logic [SIZE_FILTER_DATA-1:0] thr_l_next;
    logic [SIZE_FILTER_DATA-1:0] max_amp;
    logic [SIZE_FILTER_DATA-1:0] max_amp_next;
    logic [SIZE_TS-1:0]          max_ts;
    logic [SIZE_TS-1:0]          max_ts_next;
    logic [SIZE_WIDTH-1:0]       width_cnt;
    logic [SIZE_WIDTH-1:0]       width_next;
    logic [SIZE_DEAD-1:0]        dead_cnt;
    logic [SIZE_DEAD-1:0]        dead_next;

    logic above;
    logic issue;

    assign above     = (x_r > thr_l);
    assign state_dbg = state;

    // Free-running timestamp and the input register. The timestamp simply
    // wraps; nothing downstream treats the wrap specially.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_r   <= '0;
            x_r    <= '0;
        end else begin
            ts_cnt <= ts_cnt + SIZE_TS'(1);
            ts_r   <= ts_cnt;
            x_r    <= input_data;
        end
    end

    // FSM and pulse-tracking registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            thr_l     <= '0;
            max_amp   <= '0;
            max_ts    <= '0;
            width_cnt <= '0;
            dead_cnt  <= '0;
        end else begin
            state     <= state_next;
            thr_l     <= thr_l_next;
            max_amp   <= max_amp_next;
            max_ts    <= max_ts_next;
            width_cnt <= width_next;
            dead_cnt  <= dead_next;
        end
    end

    always_comb begin
        state_next   = state;
        thr_l_next   = thr_l;
        max_amp_next = max_amp;
        max_ts_next  = max_ts;
        width_next   = width_cnt;
        dead_next    = dead_cnt;
        issue        = 1'b0;

        case (state)
            ST_IDLE: begin
                // The threshold only follows the input while idle, so a
                // change during a pulse or hold-off waits for the next idle.
                thr_l_next = threshold;
                if (above) begin
                    state_next   = ST_PULSE;
                    max_amp_next = x_r;
                    max_ts_next  = ts_r;
                    width_next   = SIZE_WIDTH'(1);
                end
            end

            ST_PULSE: begin
                if (above) begin
                    if (width_cnt != '1) begin
                        width_next = width_cnt + SIZE_WIDTH'(1);
                    end
                    // Strict compare: equal later samples keep the earlier ts.
                    if (x_r > max_amp) begin
                        max_amp_next = x_r;
                        max_ts_next  = ts_r;
                    end
                end else begin
                    issue      = 1'b1;
                    dead_next  = dead_time;
                    state_next = ST_DEAD;
                end
            end

            ST_DEAD: begin
                // Count down first; once at zero, leave only after the input
                // has dropped, so a pulse straddling expiry is never reported.
                if (dead_cnt != '0) begin
                    dead_next = dead_cnt - SIZE_DEAD'(1);
                end else if (!above) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Single-entry output register. A new report replaces the held one only
    // when the held one is being taken in the same cycle; otherwise the new
    // report is discarded and counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt.peak_valid <= 1'b0;
            rpt.peak_amp   <= '0;
            rpt.peak_ts    <= '0;
            rpt.peak_width <= '0;
            lost_count     <= '0;
        end else if (issue) begin
            if (!rpt.peak_valid || rpt.peak_ready) begin
                rpt.peak_valid <= 1'b1;
                rpt.peak_amp   <= max_amp;
                rpt.peak_ts    <= max_ts;
                rpt.peak_width <= width_cnt;
            end else if (lost_count != 16'hFFFF) begin
                lost_count <= lost_count + 16'd1;
            end
        end else if (rpt.peak_valid && rpt.peak_ready) begin
            rpt.peak_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peak_detector.sv
module tb_peak_detector;

    logic        clk;
    logic        reset;
    logic [15:0] input_data;
    logic [15:0] threshold;
    logic [7:0]  dead_time;
    logic [15:0] lost_count;
    logic [1:0]  state_dbg;
    logic [15:0] w_lost_count;
    logic [1:0]  w_state_dbg;

    peak_detector_if pk_if ();
    peak_detector_if #(.SIZE_TS(8)) w_if ();

    assign w_if.peak_ready = pk_if.peak_ready;

    peak_detector dut (
        .clk        (clk),
        .reset      (reset),
        .input_data (input_data),
        .threshold  (threshold),
        .dead_time  (dead_time),
        .rpt        (pk_if),
        .lost_count (lost_count),
        .state_dbg  (state_dbg)
    );

    // Second instance with an 8-bit timestamp so a wrap is reachable quickly.
    peak_detector #(.SIZE_TS(8)) dut_w (
        .clk        (clk),
        .reset      (reset),
        .input_data (input_data),
        .threshold  (threshold),
        .dead_time  (dead_time),
        .rpt        (w_if),
        .lost_count (w_lost_count),
        .state_dbg  (w_state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rst;
        int data;
        int thr;
        int dead;
        bit rdy;
        bit ev;
        int amp;
        int ts;
        int w;
        int lost;
    } vec_t;

    vec_t tbl[$];

    int cfg_thr  = 100;
    int cfg_dead = 4;
    bit cfg_rdy  = 1'b1;
    int cfg_lost = 0;
    bit cfg_rst  = 1'b0;

    task automatic push(input int d, input bit ev, input int amp, input int ts, input int w);
        vec_t v;
        v.rst  = cfg_rst;
        v.data = d;
        v.thr  = cfg_thr;
        v.dead = cfg_dead;
        v.rdy  = cfg_rdy;
        v.ev   = ev;
        v.amp  = amp;
        v.ts   = ts;
        v.w    = w;
        v.lost = cfg_lost;
        tbl.push_back(v);
        cfg_rst = 1'b0;
    endtask

    // Vector expecting no report on the output.
    task automatic p(input int d);
        push(d, 1'b0, 0, 0, 0);
    endtask

    // Vector expecting a report with the given payload.
    task automatic q(input int d, input int amp, input int ts, input int w);
        push(d, 1'b1, amp, ts, w);
    endtask

    task automatic seg(input int thr, input int dead, input bit rdy);
        cfg_rst  = 1'b1;
        cfg_thr  = thr;
        cfg_dead = dead;
        cfg_rdy  = rdy;
        cfg_lost = 0;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; holds reset across one rising edge.
    task automatic apply_reset();
        reset      = 1'b1;
        input_data = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input int d);
        input_data = 16'(d);
        @(negedge clk);
    endtask

    task automatic check_report(input string tag, input int amp, input int ts, input int w);
        check({tag, " valid"}, 32'(pk_if.peak_valid), 32'd1);
        check({tag, " amp"},   32'(pk_if.peak_amp),   32'(amp));
        check({tag, " ts"},    pk_if.peak_ts,         32'(ts));
        check({tag, " width"}, 32'(pk_if.peak_width), 32'(w));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset            = 1'b1;
        input_data       = '0;
        threshold        = 16'd100;
        dead_time        = 8'd4;
        pk_if.peak_ready = 1'b1;

        // Single pulse: first 150 captured at edge 10.
        seg(100, 4, 1'b1);
        for (int k = 0; k < 10; k++) p(0);
        p(150); p(300); p(500); p(400); p(200); p(50);
        q(0, 500, 12, 5);
        p(0);

        // Equal maxima; threshold raised mid-pulse must not cut it short.
        seg(100, 4, 1'b1);
        for (int k = 0; k < 20; k++) p(0);
        p(120); p(300);
        cfg_thr = 400;
        p(300); p(110);
        cfg_thr = 100;
        p(0);
        q(0, 300, 21, 4);
        p(0);

        // Dead time: second pulse arrives during hold-off and is still high
        // at expiry; only the later re-crossing reports.
        seg(100, 10, 1'b1);
        for (int k = 0; k < 5; k++) p(0);
        p(200); p(0);
        q(0, 200, 5, 1);
        p(0);
        for (int k = 0; k < 11; k++) p(250);
        p(0); p(0); p(0);
        p(180); p(0);
        q(0, 180, 23, 1);
        p(0);

        // Back-pressure: held report stays, later reports counted as lost;
        // then an issue coinciding with acceptance replaces the report.
        seg(100, 0, 1'b0);
        p(0); p(0); p(0);
        p(200); p(0);
        q(0, 200, 3, 1); q(300, 200, 3, 1); q(0, 200, 3, 1);
        cfg_lost = 1;
        q(0, 200, 3, 1); q(400, 200, 3, 1); q(0, 200, 3, 1);
        cfg_lost = 2;
        q(0, 200, 3, 1);
        cfg_rdy = 1'b1;
        p(0); p(0);
        cfg_rdy = 1'b0;
        p(0); p(150); p(0);
        q(0, 150, 15, 1); q(160, 150, 15, 1); q(0, 150, 15, 1);
        cfg_rdy = 1'b1;
        q(0, 160, 18, 1);
        p(0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset valid", 32'(pk_if.peak_valid), 32'd0);
        check("reset amp",   32'(pk_if.peak_amp),   32'd0);
        check("reset ts",    pk_if.peak_ts,         32'd0);
        check("reset width", 32'(pk_if.peak_width), 32'd0);
        check("reset lost",  32'(lost_count),       32'd0);
        check("reset state", 32'(state_dbg),        32'd0);

        // Table run.
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) apply_reset();
            input_data       = 16'(tbl[i].data);
            threshold        = 16'(tbl[i].thr);
            dead_time        = 8'(tbl[i].dead);
            pk_if.peak_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d valid", i), 32'(pk_if.peak_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d lost", i),  32'(lost_count),       32'(tbl[i].lost));
            if (tbl[i].ev) begin
                check($sformatf("vec%0d amp", i),   32'(pk_if.peak_amp),   32'(tbl[i].amp));
                check($sformatf("vec%0d ts", i),    pk_if.peak_ts,         32'(tbl[i].ts));
                check($sformatf("vec%0d width", i), 32'(pk_if.peak_width), 32'(tbl[i].w));
            end
        end

        // Width saturation and timestamp wrap (8-bit instance wraps at 256).
        threshold        = 16'd100;
        dead_time        = 8'd0;
        pk_if.peak_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 5; k++) drive(0);
        for (int k = 0; k < 299; k++) drive(1000);
        drive(1001);
        drive(0);
        check("sat pre valid", 32'(pk_if.peak_valid), 32'd0);
        drive(0);
        check_report("sat", 1001, 304, 255);
        check("wrap valid", 32'(w_if.peak_valid), 32'd1);
        check("wrap amp",   32'(w_if.peak_amp),   32'd1001);
        check("wrap ts",    32'(w_if.peak_ts),    32'd48);
        check("wrap width", 32'(w_if.peak_width), 32'd255);

        // Asynchronous reset while a report is pending and a loss is counted.
        pk_if.peak_ready = 1'b0;
        apply_reset();
        drive(0); drive(0); drive(300); drive(0); drive(0);
        check_report("pend", 300, 2, 1);
        drive(400); drive(0); drive(0);
        check("pend lost", 32'(lost_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async valid", 32'(pk_if.peak_valid), 32'd0);
        check("async amp",   32'(pk_if.peak_amp),   32'd0);
        check("async ts",    pk_if.peak_ts,         32'd0);
        check("async width", 32'(pk_if.peak_width), 32'd0);
        check("async lost",  32'(lost_count),       32'd0);
        @(negedge clk);
        reset            = 1'b0;
        pk_if.peak_ready = 1'b1;

        // Asynchronous reset mid-pulse discards the pulse.
        drive(0); drive(0); drive(500); drive(500);
        check("mid state pulse", 32'(state_dbg), 32'd1);
        input_data = '0;
        #2 reset = 1'b1;
        #1;
        check("mid state idle", 32'(state_dbg), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(0);
            check($sformatf("post%0d valid", k), 32'(pk_if.peak_valid), 32'd0);
            check($sformatf("post%0d lost", k),  32'(lost_count),       32'd0);
        end
        drive(700); drive(0); drive(0);
        check_report("post", 700, 6, 1);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
